uart_apb_csr: RTL

//  APB3 slave register block for the UART. Successor to the single-word combinational datapath.

---
 rtl/uart_apb_pkg.sv | 25 ++
 rtl/uart_apb_fifo.sv | 75 +++++++
 rtl/uart_apb_csr.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_apb_pkg.sv
// uart_apb_pkg
//  Shared constants for the UART APB register block:
//   - register byte addresses (ADDR_DATA .. ADDR_IRQ_EN)
//   - STATUS register bit positions
//   - baud divisor reset value
package uart_apb_pkg;

    localparam logic [7:0] ADDR_DATA   = 8'h00;
    localparam logic [7:0] ADDR_CTRL   = 8'h04;
    localparam logic [7:0] ADDR_MODE   = 8'h08;
    localparam logic [7:0] ADDR_STATUS = 8'h0C;
    localparam logic [7:0] ADDR_BAUD   = 8'h10;
    localparam logic [7:0] ADDR_IRQ_EN = 8'h14;

    localparam int ST_TX_EMPTY   = 0;
    localparam int ST_TX_FULL    = 1;
    localparam int ST_RX_EMPTY   = 2;
    localparam int ST_RX_FULL    = 3;
    localparam int ST_RX_OVF     = 4;
    localparam int ST_TX_CNT_LSB = 8;
    localparam int ST_RX_CNT_LSB = 16;

    localparam int BAUD_RST = 434;

endpackage

// File: rtl/uart_apb_fifo.sv
// uart_apb_fifo
//  Synchronous FIFO used for both the TX and RX character buffers.
//  Ports:
//   clk, rst      clock, asynchronous active-high reset
//   push, wdata   write strobe and data (ignored when full unless popping)
//   pop           read strobe (ignored when empty); rdata is the current head
//   full, empty   occupancy flags
//   count         number of stored entries, $clog2(DEPTH)+1 bits
//  A simultaneous push and pop on a full FIFO is legal: the pop frees the
//  slot that the push fills, so count is unchanged and order is preserved.
module uart_apb_fifo
    import uart_apb_pkg::*;
#(
    parameter int W     = 10,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [W-1:0]             wdata,
    input  logic                     pop,
    output logic [W-1:0]             rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    // Head must be visible combinationally (tx_data, read-data capture), so
    // this array maps to LUT RAM / flops rather than a registered-read BRAM.
    logic [W-1:0]     mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [CNT_W-1:0] count_reg;

    logic push_ok;
    logic pop_ok;

    assign full    = (count_reg == CNT_W'(DEPTH));
    assign empty   = (count_reg == '0);
    assign pop_ok  = pop & ~empty;
    assign push_ok = push & (~full | pop_ok);
    assign rdata   = mem[rd_ptr_reg];
    assign count   = count_reg;

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr_reg] <= wdata;
        end
    end

    // DEPTH is a power of two, so pointer overflow wraps mod DEPTH.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            end
            if (pop_ok) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   count_reg <= count_reg + CNT_W'(1);
                2'b01:   count_reg <= count_reg - CNT_W'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

endmodule

// File: rtl/uart_apb_csr.sv
// uart_apb_csr
//  APB3 slave register block between the APB bus and the UART TX/RX engines.
//  Holds TX/RX character FIFOs plus CTRL, MODE, BAUD and STATUS registers.
//  Ports:
//   clk, rst                         clock, asynchronous active-high reset
//   psel/penable/pwrite/paddr/pwdata APB request
//   prdata/pready/pslverr            APB response (registered at setup phase)
//   tx_data/tx_valid/tx_ready        TX engine handshake (head of TX FIFO)
//   rx_data/rx_valid                 RX engine strobe (no backpressure)
//   tx_en/rx_en/mode/baud            control outputs to the UART engines
//   irq                              only when UART_APB_IRQ_EN is defined
//  Optional feature macro: UART_APB_IRQ_EN adds irq and IRQ_EN at 0x14.
module uart_apb_csr
    import uart_apb_pkg::*;
#(
    parameter int DATA_W = 10,
    parameter int DEPTH  = 8,
    parameter int BAUD_W = 20
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              psel,
    input  logic              penable,
    input  logic              pwrite,
    input  logic [7:0]        paddr,
    input  logic [31:0]       pwdata,
    output logic [31:0]       prdata,
    output logic              pready,
    output logic              pslverr,
    output logic [DATA_W-1:0] tx_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    input  logic [DATA_W-1:0] rx_data,
    input  logic              rx_valid,
    output logic              tx_en,
    output logic              rx_en,
    output logic              mode,
    output logic [BAUD_W-1:0] baud
`ifdef UART_APB_IRQ_EN
    ,
    output logic              irq
`endif
);

    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam logic [DATA_W-1:0] LOW8_MASK = DATA_W'(8'hFF);

    logic [31:0]       prdata_reg;
    logic              pslverr_reg;
    logic              pending_reg;   // a setup phase was seen and not yet completed
    logic              tx_en_reg;
    logic              rx_en_reg;
    logic              mode_reg;
    logic              rx_ovf_reg;
    logic [BAUD_W-1:0] baud_reg;

    logic [31:0]       rdata_next;
    logic              err_next;

    logic [7:0]        addr;
    logic              setup_ph;
    logic              acc_ok;
    logic              wr_hit;
    logic              rd_hit;

    logic              tx_push;
    logic              tx_pop;
    logic [DATA_W-1:0] tx_wdata;
    logic              tx_full;
    logic              tx_empty;
    logic [CNT_W-1:0]  tx_count;

    logic              rx_push;
    logic              rx_pop;
    logic [DATA_W-1:0] rx_head;
    logic [DATA_W-1:0] rx_head_m;
    logic              rx_full;
    logic              rx_empty;
    logic [CNT_W-1:0]  rx_count;

    logic [31:0]       status;

    assign addr     = paddr & 8'hFC;
    assign setup_ph = psel & ~penable;
    // Errors were decided at setup; an erroring or reset-orphaned access
    // changes nothing on its access edge.
    assign acc_ok   = psel & penable & pending_reg & ~pslverr_reg;
    assign wr_hit   = acc_ok & pwrite;
    assign rd_hit   = acc_ok & ~pwrite;

    assign tx_wdata  = mode_reg ? pwdata[DATA_W-1:0] : (pwdata[DATA_W-1:0] & LOW8_MASK);
    assign tx_push   = wr_hit & (addr == ADDR_DATA);
    assign tx_valid  = ~tx_empty & tx_en_reg;
    assign tx_pop    = tx_valid & tx_ready;

    assign rx_push   = rx_valid & rx_en_reg;
    assign rx_pop    = rd_hit & (addr == ADDR_DATA);
    assign rx_head_m = mode_reg ? rx_head : (rx_head & LOW8_MASK);

    assign status = {8'd0, 8'(rx_count), 8'(tx_count), 3'd0,
                     rx_ovf_reg, rx_full, rx_empty, tx_full, tx_empty};

    uart_apb_fifo #(.W(DATA_W), .DEPTH(DEPTH)) u_tx_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (tx_push),
        .wdata (tx_wdata),
        .pop   (tx_pop),
        .rdata (tx_data),
        .full  (tx_full),
        .empty (tx_empty),
        .count (tx_count)
    );

    uart_apb_fifo #(.W(DATA_W), .DEPTH(DEPTH)) u_rx_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (rx_push),
        .wdata (rx_data),
        .pop   (rx_pop),
        .rdata (rx_head),
        .full  (rx_full),
        .empty (rx_empty),
        .count (rx_count)
    );

`ifdef UART_APB_IRQ_EN
    logic [2:0] irq_en_reg;
    logic       irq_reg;
    logic [2:0] irq_cause;

    assign irq_cause = {rx_ovf_reg, tx_empty, ~rx_empty};
    assign irq       = irq_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            irq_en_reg <= '0;
            irq_reg    <= 1'b0;
        end else begin
            if (wr_hit && addr == ADDR_IRQ_EN) begin
                irq_en_reg <= pwdata[2:0];
            end
            irq_reg <= |(irq_en_reg & irq_cause);
        end
    end
`endif

    // Response decode, evaluated during the setup phase.
    always_comb begin
        rdata_next = '0;
        err_next   = 1'b0;
        case (addr)
            ADDR_DATA: begin
                if (pwrite) begin
                    err_next = tx_full;
                end else if (rx_empty) begin
                    err_next = 1'b1;
                end else begin
                    rdata_next = 32'(rx_head_m);
                end
            end
            ADDR_CTRL: begin
                rdata_next = {30'd0, rx_en_reg, tx_en_reg};
            end
            ADDR_MODE: begin
                rdata_next = {31'd0, mode_reg};
            end
            ADDR_STATUS: begin
                if (pwrite) begin
                    err_next = |(pwdata & ~(32'd1 << ST_RX_OVF));
                end else begin
                    rdata_next = status;
                end
            end
            ADDR_BAUD: begin
                if (pwrite) begin
                    err_next = (pwdata[BAUD_W-1:0] == '0);
                end else begin
                    rdata_next = 32'(baud_reg);
                end
            end
`ifdef UART_APB_IRQ_EN
            ADDR_IRQ_EN: begin
                rdata_next = {29'd0, irq_en_reg};
            end
`endif
            default: begin
                err_next = 1'b1;
            end
        endcase
        if (pwrite) begin
            rdata_next = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prdata_reg  <= '0;
            pslverr_reg <= 1'b0;
            pending_reg <= 1'b0;
            tx_en_reg   <= 1'b0;
            rx_en_reg   <= 1'b0;
            mode_reg    <= 1'b0;
            rx_ovf_reg  <= 1'b0;
            baud_reg    <= BAUD_W'(BAUD_RST);
        end else begin
            if (setup_ph) begin
                prdata_reg  <= rdata_next;
                pslverr_reg <= err_next;
                pending_reg <= 1'b1;
            end else if (!psel || penable) begin
                pending_reg <= 1'b0;
            end

            if (wr_hit) begin
                case (addr)
                    ADDR_CTRL: begin
                        tx_en_reg <= pwdata[0];
                        rx_en_reg <= pwdata[1];
                    end
                    ADDR_MODE: mode_reg <= pwdata[0];
                    ADDR_BAUD: baud_reg <= pwdata[BAUD_W-1:0];
                    default: ;
                endcase
            end

            // A new overflow wins over a simultaneous W1C.
            if (rx_push && rx_full && !rx_pop) begin
                rx_ovf_reg <= 1'b1;
            end else if (wr_hit && addr == ADDR_STATUS && pwdata[ST_RX_OVF]) begin
                rx_ovf_reg <= 1'b0;
            end
        end
    end

    assign prdata  = prdata_reg;
    assign pslverr = pslverr_reg;
    assign pready  = 1'b1;
    assign tx_en   = tx_en_reg;
    assign rx_en   = rx_en_reg;
    assign mode    = mode_reg;
    assign baud    = baud_reg;

endmodule
